// File: rtl/print_tx_engine_if.sv
// rtl/print_tx_engine_if.sv - print request and UART byte-stream signals of the print engine
interface print_tx_engine_if;
    logic        req_tx;
    logic        type_tx;
    logic [31:0] dout_tx;
    logic        ack_tx;
    logic [7:0]  d_tx;
    logic        vld_tx;
    logic        rdy_tx;

    modport master (
        output req_tx, type_tx, dout_tx, rdy_tx,
        input  ack_tx, d_tx, vld_tx
    );

    modport slave (
        input  req_tx, type_tx, dout_tx, rdy_tx,
        output ack_tx, d_tx, vld_tx
    );
endinterface

// File: rtl/print_tx_engine.sv
// rtl/print_tx_engine.sv - serializes a raw char or hex word print request onto a UART byte stream
module print_tx_engine #(
    parameter int         HEX_DIGITS = 8,
    parameter logic [7:0] SEP_CHAR   = 8'h20,
    parameter bit         UPPER_HEX  = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    print_tx_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        type_q, type_d;
    logic [7:0]  d_tx_q, d_tx_d;
    logic        vld_q, vld_d;
    logic        ack_q, ack_d;
    logic        last_byte;

    // Byte idx of a print: raw char, or hex digit MSB nibble first, then the separator.
    function automatic logic [7:0] byte_at(input logic [3:0] idx, input logic [31:0] data,
                                           input logic typ);
        logic [31:0] sh;
        logic [3:0]  nib;
        logic [7:0]  b;
        b   = data[7:0];
        sh  = '0;
        nib = '0;
        if (typ) begin
            if (idx >= 4'(HEX_DIGITS)) begin
                b = SEP_CHAR;
            end else begin
                sh  = data >> (6'(4 * (HEX_DIGITS - 1)) - {idx, 2'b00});
                nib = sh[3:0];
                if (nib < 4'd10) b = 8'h30 + {4'h0, nib};
                else             b = (UPPER_HEX ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
            end
        end
        return b;
    endfunction

    assign last_byte = type_q ? (cnt_q == 4'(HEX_DIGITS)) : (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        type_d  = type_q;
        d_tx_d  = d_tx_q;
        vld_d   = vld_q;
        ack_d   = 1'b0;

        // Re-arming on any low sample keeps a held request from printing twice.
        if (!bus.req_tx) armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.req_tx && armed_q) begin
                    armed_d = 1'b0;
                    data_d  = bus.dout_tx;
                    type_d  = bus.type_tx;
                    cnt_d   = 4'd0;
                    d_tx_d  = byte_at(4'd0, bus.dout_tx, bus.type_tx);
                    vld_d   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (vld_q && bus.rdy_tx) begin
                    cnt_d = cnt_q + 4'd1;
                    if (last_byte) begin
                        vld_d   = 1'b0;
                        ack_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        d_tx_d = byte_at(cnt_q + 4'd1, data_q, type_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            cnt_q   <= 4'd0;
            data_q  <= 32'd0;
            type_q  <= 1'b0;
            d_tx_q  <= 8'h00;
            vld_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            type_q  <= type_d;
            d_tx_q  <= d_tx_d;
            vld_q   <= vld_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.d_tx   = d_tx_q;
    assign bus.vld_tx = vld_q;
    assign bus.ack_tx = ack_q;

endmodule
